// File: rtl/pwm_rgb_driver.sv
// pwm_rgb_driver: three-channel PWM LED driver with double-buffered duty/enable updates applied at period boundaries.
// Define PWM_ACTIVE_LOW_EN for inverted (common-anode) LED pins; default build drives active-high pins.
module pwm_rgb_driver #(
    parameter int unsigned PWM_INTERVAL = 1200,
    parameter int unsigned DUTY_W       = $clog2(PWM_INTERVAL + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] pwm_value,
    input  logic              red_en,
    input  logic              green_en,
    input  logic              blue_en,
    input  logic              duty_load,
    output logic              led_r,
    output logic              led_g,
    output logic              led_b,
    output logic              period_start
);
`ifdef PWM_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif
    localparam logic [DUTY_W-1:0] LAST = DUTY_W'(PWM_INTERVAL - 1);
    localparam logic [DUTY_W-1:0] FULL = DUTY_W'(PWM_INTERVAL);

    logic [DUTY_W-1:0] cnt;
    logic [DUTY_W-1:0] pend_duty;
    logic [DUTY_W-1:0] act_duty;
    logic [DUTY_W-1:0] load_duty;
    logic [2:0]        pend_en;
    logic [2:0]        act_en;
    logic [2:0]        load_en;
    logic [2:0]        on;
    logic              pend_valid;
    logic              running;

    always_comb begin
        load_duty = (pwm_value > FULL) ? FULL : pwm_value;
        load_en   = {red_en, green_en, blue_en};
        on        = act_en & {3{cnt < act_duty}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            running      <= 1'b0;
            pend_duty    <= '0;
            pend_en      <= '0;
            pend_valid   <= 1'b0;
            act_duty     <= '0;
            act_en       <= '0;
            period_start <= 1'b0;
            led_r        <= INV;
            led_g        <= INV;
            led_b        <= INV;
        end else begin
            running <= 1'b1;
            // First edge after reset only shows cnt==0; counting and compare start on the next edge.
            if (running) begin
                cnt          <= (cnt == LAST) ? '0 : cnt + DUTY_W'(1);
                period_start <= (cnt == '0);
                led_r        <= on[2] ^ INV;
                led_g        <= on[1] ^ INV;
                led_b        <= on[0] ^ INV;
            end

            // A load in the boundary cycle bypasses the pending stage.
            if (cnt == LAST) begin
                if (duty_load) begin
                    act_duty <= load_duty;
                    act_en   <= load_en;
                end else if (pend_valid) begin
                    act_duty <= pend_duty;
                    act_en   <= pend_en;
                end
                pend_valid <= 1'b0;
            end else if (duty_load) begin
                pend_duty  <= load_duty;
                pend_en    <= load_en;
                pend_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pwm_rgb_driver.sv
// Self-checking bench for pwm_rgb_driver (PWM_INTERVAL=8); follows PWM_ACTIVE_LOW_EN for pin polarity.
module tb_pwm_rgb_driver;
    localparam int unsigned N = 8;
    localparam int unsigned W = $clog2(N + 1);
`ifdef PWM_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] pwm_value = '0;
    logic         red_en = 1'b0, green_en = 1'b0, blue_en = 1'b0, duty_load = 1'b0;
    logic         led_r, led_g, led_b, period_start;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned e = 0;   // clk edges since reset release

    // A load sampled at edge le governs every period from its apply index on, until a later load.
    typedef struct {
        int unsigned per;
        int unsigned duty;
        logic [2:0]  en;
    } load_t;
    load_t loads[$];

    pwm_rgb_driver #(.PWM_INTERVAL(N)) dut (
        .clk(clk), .rst(rst), .pwm_value(pwm_value),
        .red_en(red_en), .green_en(green_en), .blue_en(blue_en),
        .duty_load(duty_load),
        .led_r(led_r), .led_g(led_g), .led_b(led_b),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    // Expected {period_start, r, g, b} after edge k: period p covers edges 2+8p .. 9+8p.
    function automatic logic [3:0] expect_out(input int unsigned k);
        int unsigned pos, per, d;
        logic [2:0]  en;
        if (k < 2) return {1'b0, {3{INV}}};
        pos = (k - 2) % N;
        per = (k - 2) / N;
        d   = 0;
        en  = 3'b000;
        foreach (loads[i])
            if (loads[i].per <= per) begin
                d  = loads[i].duty;
                en = loads[i].en;
            end
        return {pos == 0, (en & {3{pos < d}}) ^ {3{INV}}};
    endfunction

    function automatic logic [3:0] obs();
        return {period_start, led_r, led_g, led_b};
    endfunction

    task automatic step(input logic ld, input int unsigned v, input logic [2:0] en);
        duty_load = ld;
        pwm_value = W'(v);
        {red_en, green_en, blue_en} = en;
        @(posedge clk);
        e++;
        if (ld) loads.push_back('{(e < 2) ? 1 : (e + N - 2) / N, (v > N) ? N : v, en});
        #1;
        duty_load = 1'b0;
    endtask

    // Advance until the DUT counter currently holds c.
    task automatic wait_pos(input int unsigned c);
        for (int i = 0; i <= int'(N) + 1; i++) begin
            if (e >= 1 && ((e - 1) % N) == c) break;
            step(1'b0, 0, 3'b000);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs() !== {1'b0, {3{INV}}}) begin
            n_bad++;
            $display("FAIL reset_hold got %b want %b", obs(), {1'b0, {3{INV}}});
        end
        rst = 1'b0;
        e = 0;
        loads.delete();
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 0, 3'b000);
            n_cmp++;
            if (obs() !== expect_out(e)) begin
                n_bad++;
                $display("FAIL reset_release e=%0d got %b want %b", e, obs(), expect_out(e));
            end
        end
    endtask

    task automatic test_duty3();
        step(1'b1, 3, 3'b100);
        for (int i = 0; i < 3 * int'(N); i++) begin
            step(1'b0, 0, 3'b000);
            n_cmp++;
            if (obs() !== expect_out(e)) begin
                n_bad++;
                $display("FAIL duty3 e=%0d got %b want %b", e, obs(), expect_out(e));
            end
        end
    endtask

    task automatic test_boundary();
        int unsigned vals[3] = '{0, 8, 15};
        foreach (vals[j]) begin
            step(1'b1, vals[j], (j == 0) ? 3'b111 : 3'(4 | $urandom_range(0, 3)));
            for (int i = 0; i < 2 * int'(N); i++) begin
                step(1'b0, 0, 3'b000);
                n_cmp++;
                if (obs() !== expect_out(e)) begin
                    n_bad++;
                    $display("FAIL boundary_%0d e=%0d got %b want %b", vals[j], e, obs(), expect_out(e));
                end
            end
        end
    endtask

    task automatic test_mid_update();
        step(1'b1, 6, 3'b111);
        repeat (2 * N) step(1'b0, 0, 3'b000);
        wait_pos(2);
        step(1'b1, 2, 3'b111);
        wait_pos(1);
        step(1'b1, 4, 3'b110);
        wait_pos(4);
        step(1'b1, 5, 3'b101);
        for (int i = 0; i < 2 * int'(N); i++) begin
            step(1'b0, 0, 3'b000);
            n_cmp++;
            if (obs() !== expect_out(e)) begin
                n_bad++;
                $display("FAIL mid_update e=%0d got %b want %b", e, obs(), expect_out(e));
            end
        end
    endtask

    task automatic test_coincident();
        wait_pos(7);
        step(1'b1, 5, 3'b111);
        for (int i = 0; i < 2 * int'(N); i++) begin
            step(1'b0, 0, 3'b000);
            n_cmp++;
            if (obs() !== expect_out(e)) begin
                n_bad++;
                $display("FAIL coincident e=%0d got %b want %b", e, obs(), expect_out(e));
            end
        end
        n_cmp++;
        if (dut.pend_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL coincident_pend got %b want 0", dut.pend_valid);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 6, 3'b111);
        repeat (2 * N) step(1'b0, 0, 3'b000);
        wait_pos(4);
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== {1'b0, {3{INV}}}) begin
            n_bad++;
            $display("FAIL reset_mid_async got %b want %b", obs(), {1'b0, {3{INV}}});
        end
        @(posedge clk);
        #4 rst = 1'b0;
        e = 0;
        loads.delete();
        for (int i = 0; i < 2 * int'(N); i++) begin
            step(1'b0, 0, 3'b000);
            n_cmp++;
            if (obs() !== expect_out(e)) begin
                n_bad++;
                $display("FAIL reset_mid_after e=%0d got %b want %b", e, obs(), expect_out(e));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 120; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 15), 3'($urandom_range(0, 7)));
            n_cmp++;
            if (obs() !== expect_out(e)) begin
                n_bad++;
                $display("FAIL random e=%0d got %b want %b", e, obs(), expect_out(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_duty3();
        test_boundary();
        test_mid_update();
        test_coincident();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
